// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the unified instruction/data memory: CPU and loader ports.
// Round-robin by default; define ARB_FIXED_PRIO_EN to give the CPU fixed priority.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ldr_ack,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_ldr
);

  localparam int unsigned CntW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_t;

  state_t          state;
  logic [CntW-1:0] cnt;
  logic            we_q;
  logic            last_ldr;
  logic            pick_ldr;

  always_comb begin
    pick_ldr = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
    pick_ldr = ldr_req & ~cpu_req;
`else
    // On a tie the port that did not win last time gets the grant.
    pick_ldr = ldr_req & (~cpu_req | ~last_ldr);
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= StIdle;
      cnt       <= '0;
      we_q      <= 1'b0;
      last_ldr  <= 1'b1;
      grant_ldr <= 1'b0;
      busy      <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      ldr_rdata <= '0;
      cpu_ack   <= 1'b0;
      ldr_ack   <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      ldr_ack <= 1'b0;
      unique case (state)
        StIdle: begin
          if (cpu_req || ldr_req) begin
            state     <= StAccess;
            busy      <= 1'b1;
            grant_ldr <= pick_ldr;
            last_ldr  <= pick_ldr;
            cnt       <= CntW'(MEM_LAT - 1);
            if (pick_ldr) begin
              mem_addr  <= ldr_addr;
              mem_wdata <= ldr_wdata;
              we_q      <= ldr_we;
              mem_read  <= ~ldr_we;
              mem_write <= ldr_we;
            end else begin
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
              we_q      <= cpu_we;
              mem_read  <= ~cpu_we;
              mem_write <= cpu_we;
            end
          end
        end
        StAccess: begin
          if (cnt == '0) begin
            state     <= StDone;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (grant_ldr) begin
              ldr_ack <= 1'b1;
              if (!we_q) ldr_rdata <= mem_rdata;
            end else begin
              cpu_ack <= 1'b1;
              if (!we_q) cpu_rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        StDone: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized
// transaction-level model of arbitration order and read data (MEM_LAT=2 and MEM_LAT=1).
module tb_mem_port_arbiter;
  localparam int unsigned LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic        cpu_req, cpu_we, ldr_req, ldr_we;
  logic [31:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;
  logic [31:0] cpu_rdata, ldr_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_ack, ldr_ack, mem_read, mem_write, busy, grant_ldr;

  logic        b_cpu_req, b_cpu_we, b_ldr_req, b_ldr_we;
  logic [31:0] b_cpu_addr, b_cpu_wdata, b_ldr_addr, b_ldr_wdata;
  logic [31:0] b_cpu_rdata, b_ldr_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic        b_cpu_ack, b_ldr_ack, b_mem_read, b_mem_write, b_busy, b_grant_ldr;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference expectations, derived only from the rules of the arbiter.
  logic [31:0] exp_cpu_rd, exp_ldr_rd;
  logic        last_ldr;
  logic [31:0] ref_mem [64];
  logic [63:0] ref_vld = '0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
    .clk(clk), .reset(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_rdata(ldr_rdata), .ldr_ack(ldr_ack),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .grant_ldr(grant_ldr)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut_b (
    .clk(clk), .reset(rst),
    .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
    .cpu_rdata(b_cpu_rdata), .cpu_ack(b_cpu_ack),
    .ldr_req(b_ldr_req), .ldr_we(b_ldr_we), .ldr_addr(b_ldr_addr), .ldr_wdata(b_ldr_wdata),
    .ldr_rdata(b_ldr_rdata), .ldr_ack(b_ldr_ack),
    .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy), .grant_ldr(b_grant_ldr)
  );

  function automatic logic [31:0] init_val(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_vld[a[7:2]] ? ref_mem[a[7:2]] : init_val(a);
  endfunction

  // Memory environment: 64 words, unwritten words return init_val.
  logic [31:0] env_mem [64];
  logic [63:0] env_vld = '0;
  always @(posedge clk) begin
    if (mem_write) begin
      env_mem[mem_addr[7:2]] <= mem_wdata;
      env_vld[mem_addr[7:2]] <= 1'b1;
    end
  end
  assign mem_rdata = !mem_read ? 32'h0 :
                     env_vld[mem_addr[7:2]] ? env_mem[mem_addr[7:2]] : init_val(mem_addr);
  assign b_mem_rdata = b_mem_read ? init_val(b_mem_addr) : 32'h0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0;
    b_cpu_req = 0; b_cpu_we = 0; b_cpu_addr = 0; b_cpu_wdata = 0;
    b_ldr_req = 0; b_ldr_we = 0; b_ldr_addr = 0; b_ldr_wdata = 0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 0;
    tick(); tick();
    total_cnt++;
    if ({mem_read, mem_write, cpu_ack, ldr_ack, busy, grant_ldr} !== 6'b0)
      $display("FAIL reset_ctrl: got %b want 000000",
               {mem_read, mem_write, cpu_ack, ldr_ack, busy, grant_ldr});
    else pass_cnt++;
    total_cnt++;
    if ({mem_addr, mem_wdata, cpu_rdata, ldr_rdata} !== 128'h0)
      $display("FAIL reset_data: got %h %h %h %h want 0", mem_addr, mem_wdata, cpu_rdata,
               ldr_rdata);
    else pass_cnt++;
    total_cnt++;
    if ({b_mem_read, b_mem_write, b_cpu_ack, b_ldr_ack, b_busy, b_grant_ldr} !== 6'b0)
      $display("FAIL reset_lat1: got %b want 000000",
               {b_mem_read, b_mem_write, b_cpu_ack, b_ldr_ack, b_busy, b_grant_ldr});
    else pass_cnt++;
    exp_cpu_rd = 0; exp_ldr_rd = 0; last_ldr = 1;
    rst = 1;
    tick();
  endtask

  task automatic test_cpu_read;
    int rd_cyc, wr_cyc, addr_bad, ack_at, acks, ldr_acks;
    logic [31:0] got;
    rd_cyc = 0; wr_cyc = 0; addr_bad = 0; ack_at = -1; acks = 0; ldr_acks = 0; got = 0;
    cpu_we = 0; cpu_addr = 32'h10; cpu_req = 1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (mem_read) begin
        rd_cyc++;
        if (mem_addr !== 32'h10) addr_bad++;
      end
      if (mem_write) wr_cyc++;
      if (ldr_ack) ldr_acks++;
      if (cpu_ack) begin
        acks++;
        if (ack_at < 0) ack_at = c;
        got = cpu_rdata;
        cpu_req = 0;
      end
    end
    total_cnt++;
    if (rd_cyc !== LAT || wr_cyc !== 0)
      $display("FAIL cpu_read_strobes: got rd=%0d wr=%0d want rd=%0d wr=0", rd_cyc, wr_cyc, LAT);
    else pass_cnt++;
    total_cnt++;
    if (addr_bad !== 0) $display("FAIL cpu_read_addr: got %0d bad cycles want 0", addr_bad);
    else pass_cnt++;
    total_cnt++;
    if (ack_at !== LAT + 1 || acks !== 1)
      $display("FAIL cpu_read_ack: got at=%0d n=%0d want at=%0d n=1", ack_at, acks, LAT + 1);
    else pass_cnt++;
    total_cnt++;
    if (got !== 32'hDEADBEEF) $display("FAIL cpu_read_data: got %h want deadbeef", got);
    else pass_cnt++;
    total_cnt++;
    if (ldr_acks !== 0) $display("FAIL cpu_read_ldr_ack: got %0d want 0", ldr_acks);
    else pass_cnt++;
    exp_cpu_rd = 32'hDEADBEEF; last_ldr = 0;
  endtask

  task automatic test_ldr_write;
    int wr_cyc, rd_cyc, wd_bad, gl_bad, ack_at, cpu_acks;
    wr_cyc = 0; rd_cyc = 0; wd_bad = 0; gl_bad = 0; ack_at = -1; cpu_acks = 0;
    ldr_we = 1; ldr_addr = 32'h40; ldr_wdata = 32'h12345678; ldr_req = 1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (mem_write) begin
        wr_cyc++;
        if (mem_wdata !== 32'h12345678 || mem_addr !== 32'h40) wd_bad++;
        if (grant_ldr !== 1'b1) gl_bad++;
      end
      if (mem_read) rd_cyc++;
      if (cpu_ack) cpu_acks++;
      if (ldr_ack && ack_at < 0) begin
        ack_at = c;
        ldr_req = 0;
      end
    end
    ref_mem[16] = 32'h12345678; ref_vld[16] = 1'b1;
    total_cnt++;
    if (wr_cyc !== LAT || rd_cyc !== 0)
      $display("FAIL ldr_write_strobes: got wr=%0d rd=%0d want wr=%0d rd=0", wr_cyc, rd_cyc, LAT);
    else pass_cnt++;
    total_cnt++;
    if (wd_bad !== 0 || gl_bad !== 0)
      $display("FAIL ldr_write_bus: got %0d/%0d bad cycles want 0", wd_bad, gl_bad);
    else pass_cnt++;
    total_cnt++;
    if (ack_at !== LAT + 1 || cpu_acks !== 0)
      $display("FAIL ldr_write_ack: got at=%0d cpu=%0d want at=%0d cpu=0", ack_at, cpu_acks,
               LAT + 1);
    else pass_cnt++;
    total_cnt++;
    if (cpu_rdata !== exp_cpu_rd || ldr_rdata !== exp_ldr_rd)
      $display("FAIL ldr_write_rdata_hold: got %h %h want %h %h", cpu_rdata, ldr_rdata,
               exp_cpu_rd, exp_ldr_rd);
    else pass_cnt++;
    last_ldr = 1;
  endtask

  task automatic test_round_robin;
    int order[$];
    for (int r = 0; r < 3; r++) begin
      cpu_we = 0; ldr_we = 0;
      cpu_addr = 32'($urandom_range(0, 63)) * 4;
      ldr_addr = 32'($urandom_range(0, 63)) * 4;
      cpu_req = 1; ldr_req = 1;
      for (int c = 0; c < 30 && (cpu_req || ldr_req); c++) begin
        tick();
        if (cpu_ack) begin
          order.push_back(0);
          exp_cpu_rd = ref_read(cpu_addr);
          total_cnt++;
          if (cpu_rdata !== exp_cpu_rd)
            $display("FAIL rr_cpu_data: got %h want %h", cpu_rdata, exp_cpu_rd);
          else pass_cnt++;
          cpu_req = 0;
        end
        if (ldr_ack) begin
          order.push_back(1);
          exp_ldr_rd = ref_read(ldr_addr);
          total_cnt++;
          if (ldr_rdata !== exp_ldr_rd)
            $display("FAIL rr_ldr_data: got %h want %h", ldr_rdata, exp_ldr_rd);
          else pass_cnt++;
          ldr_req = 0;
        end
      end
      cpu_req = 0; ldr_req = 0;
      tick();
    end
    total_cnt++;
    if (order.size() !== 6) $display("FAIL rr_count: got %0d want 6", order.size());
    else pass_cnt++;
    for (int i = 0; i < order.size() && i < 6; i++) begin
      total_cnt++;
      if (order[i] !== (i % 2)) $display("FAIL rr_order[%0d]: got %0d want %0d", i, order[i], i % 2);
      else pass_cnt++;
    end
    last_ldr = 1;
  endtask

  // Both requests held high continuously.
  task automatic test_back_to_back;
    int who[$];
    int at[$];
    int ldr_seen;
    ldr_seen = 0;
    cpu_we = 0; ldr_we = 0;
    cpu_addr = 32'($urandom_range(0, 63)) * 4;
    ldr_addr = 32'($urandom_range(0, 63)) * 4;
    cpu_req = 1; ldr_req = 1;
    for (int c = 1; c <= 40 && who.size() < 4; c++) begin
      tick();
      if (ldr_ack) ldr_seen++;
      if (cpu_ack) begin who.push_back(0); at.push_back(c); end
      if (ldr_ack) begin who.push_back(1); at.push_back(c); end
    end
    cpu_req = 0; ldr_req = 0;
    tick(); tick();
    total_cnt++;
    if (who.size() !== 4) $display("FAIL b2b_count: got %0d want 4", who.size());
    else pass_cnt++;
    for (int i = 0; i < who.size() && i < 4; i++) begin
`ifdef ARB_FIXED_PRIO_EN
      total_cnt++;
      if (who[i] !== 0) $display("FAIL b2b_fixed[%0d]: got %0d want 0", i, who[i]);
      else pass_cnt++;
`else
      total_cnt++;
      if (who[i] !== (i % 2)) $display("FAIL b2b_rr[%0d]: got %0d want %0d", i, who[i], i % 2);
      else pass_cnt++;
`endif
      if (i > 0) begin
        total_cnt++;
        if (at[i] - at[i-1] !== LAT + 2)
          $display("FAIL b2b_period[%0d]: got %0d want %0d", i, at[i] - at[i-1], LAT + 2);
        else pass_cnt++;
      end
    end
`ifdef ARB_FIXED_PRIO_EN
    total_cnt++;
    if (ldr_seen !== 0) $display("FAIL b2b_ldr_starve: got %0d ldr acks want 0", ldr_seen);
    else pass_cnt++;
    exp_cpu_rd = ref_read(cpu_addr); last_ldr = 0;
`else
    exp_cpu_rd = ref_read(cpu_addr); exp_ldr_rd = ref_read(ldr_addr); last_ldr = 1;
`endif
    total_cnt++;
    if (cpu_rdata !== exp_cpu_rd || ldr_rdata !== exp_ldr_rd)
      $display("FAIL b2b_rdata: got %h %h want %h %h", cpu_rdata, ldr_rdata, exp_cpu_rd,
               exp_ldr_rd);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int first_who, first_at, ldr_acks, found;
    logic [31:0] got;
    first_who = -1; first_at = -1; ldr_acks = 0; found = 0; got = 0;
    cpu_we = 0; cpu_addr = 32'h20; cpu_req = 1;
    for (int c = 0; c < 10 && found == 0; c++) begin
      tick();
      if (mem_read) found = 1;
    end
    total_cnt++;
    if (found !== 1) $display("FAIL rst_mid_start: got no strobe want strobe");
    else pass_cnt++;
    tick();
    rst = 0;
    tick();
    total_cnt++;
    if ({mem_read, cpu_ack, ldr_ack, busy, grant_ldr} !== 5'b0)
      $display("FAIL rst_mid_abort: got %b want 00000", {mem_read, cpu_ack, ldr_ack, busy,
               grant_ldr});
    else pass_cnt++;
    exp_cpu_rd = 0; exp_ldr_rd = 0; last_ldr = 1;
    rst = 1;
    ldr_we = 0; ldr_addr = 32'h24; ldr_req = 1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (cpu_ack) begin
        if (first_who < 0) begin first_who = 0; first_at = c; end
        got = cpu_rdata;
        cpu_req = 0;
      end
      if (ldr_ack) begin
        if (first_who < 0) begin first_who = 1; first_at = c; end
        ldr_acks++;
        ldr_req = 0;
      end
    end
    total_cnt++;
    if (first_who !== 0 || first_at !== LAT + 1)
      $display("FAIL rst_mid_resume: got who=%0d at=%0d want who=0 at=%0d", first_who, first_at,
               LAT + 1);
    else pass_cnt++;
    total_cnt++;
    if (got !== ref_read(32'h20)) $display("FAIL rst_mid_data: got %h want %h", got,
                                           ref_read(32'h20));
    else pass_cnt++;
    total_cnt++;
    if (ldr_acks !== 1) $display("FAIL rst_mid_ldr: got %0d acks want 1", ldr_acks);
    else pass_cnt++;
    exp_cpu_rd = ref_read(32'h20); exp_ldr_rd = ref_read(32'h24); last_ldr = 1;
  endtask

  task automatic test_drop_mid;
    int rd_cyc, acks, found;
    logic [31:0] got;
    rd_cyc = 0; acks = 0; found = 0; got = 0;
    cpu_we = 0; cpu_addr = 32'h8; cpu_req = 1;
    for (int c = 0; c < 10 && found == 0; c++) begin
      tick();
      if (mem_read) begin found = 1; rd_cyc++; end
    end
    cpu_req = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (mem_read) rd_cyc++;
      if (cpu_ack) begin acks++; got = cpu_rdata; end
    end
    total_cnt++;
    if (rd_cyc !== LAT || acks !== 1)
      $display("FAIL drop_mid: got rd=%0d acks=%0d want rd=%0d acks=1", rd_cyc, acks, LAT);
    else pass_cnt++;
    total_cnt++;
    if (got !== ref_read(32'h8)) $display("FAIL drop_mid_data: got %h want %h", got,
                                          ref_read(32'h8));
    else pass_cnt++;
    exp_cpu_rd = ref_read(32'h8); last_ldr = 0;
  endtask

  task automatic test_lat1;
    int rd_cyc, n, at1, at2, ldr_acks;
    logic [31:0] got1, got2;
    rd_cyc = 0; n = 0; at1 = -1; at2 = -1; ldr_acks = 0; got1 = 0; got2 = 0;
    b_cpu_we = 0; b_cpu_addr = 32'h0; b_cpu_req = 1;
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (b_mem_read) rd_cyc++;
      if (b_ldr_ack) ldr_acks++;
      if (b_cpu_ack) begin
        n++;
        if (n == 1) begin at1 = c; got1 = b_cpu_rdata; b_cpu_addr = 32'h4; end
        if (n == 2) begin at2 = c; got2 = b_cpu_rdata; b_cpu_req = 0; end
      end
    end
    total_cnt++;
    if (n !== 2 || rd_cyc !== 2 || ldr_acks !== 0)
      $display("FAIL lat1_count: got acks=%0d rd=%0d ldr=%0d want 2 2 0", n, rd_cyc, ldr_acks);
    else pass_cnt++;
    total_cnt++;
    if (at1 !== 2 || at2 - at1 !== 3)
      $display("FAIL lat1_timing: got at1=%0d gap=%0d want at1=2 gap=3", at1, at2 - at1);
    else pass_cnt++;
    total_cnt++;
    if (got1 !== init_val(32'h0) || got2 !== init_val(32'h4))
      $display("FAIL lat1_data: got %h %h want %h %h", got1, got2, init_val(32'h0),
               init_val(32'h4));
    else pass_cnt++;
  endtask

  task automatic test_random;
    int who_q[$];
    int pat, winner, front;
    logic          exp_we;
    logic [31:0]   exp_addr;
    idle_inputs();
    rst = 0;
    tick();
    rst = 1;
    exp_cpu_rd = 0; exp_ldr_rd = 0; last_ldr = 1;
    for (int r = 0; r < 25; r++) begin
      pat = $urandom_range(1, 3);
      cpu_we = 1'($urandom_range(0, 1)); ldr_we = 1'($urandom_range(0, 1));
      cpu_addr = 32'($urandom_range(0, 63)) * 4; ldr_addr = 32'($urandom_range(0, 63)) * 4;
      cpu_wdata = $urandom; ldr_wdata = $urandom;
      who_q.delete();
      if (pat == 3) begin
`ifdef ARB_FIXED_PRIO_EN
        winner = 0;
`else
        winner = last_ldr ? 0 : 1;
`endif
        who_q.push_back(winner);
        who_q.push_back(1 - winner);
      end else begin
        who_q.push_back(pat - 1);
      end
      cpu_req = pat[0]; ldr_req = pat[1];
      for (int c = 0; c < 40 && who_q.size() > 0; c++) begin
        tick();
        if ((mem_read || mem_write) && who_q.size() > 0) begin
          front = who_q[0];
          exp_we = (front == 1) ? ldr_we : cpu_we;
          exp_addr = (front == 1) ? ldr_addr : cpu_addr;
          total_cnt++;
          if ({grant_ldr, mem_write, mem_read, mem_addr} !== {front == 1, exp_we, !exp_we, exp_addr})
            $display("FAIL rand_bus r%0d: got g=%b w=%b r=%b a=%h want g=%b w=%b a=%h", r,
                     grant_ldr, mem_write, mem_read, mem_addr, front == 1, exp_we, exp_addr);
          else pass_cnt++;
        end
        if (cpu_ack || ldr_ack) begin
          front = (who_q.size() > 0) ? who_q.pop_front() : 2;
          total_cnt++;
          if ({cpu_ack, ldr_ack} !== {front == 0, front == 1})
            $display("FAIL rand_ack r%0d: got %b%b want who=%0d", r, cpu_ack, ldr_ack, front);
          else pass_cnt++;
          if (front == 0) begin
            if (cpu_we) begin ref_mem[cpu_addr[7:2]] = cpu_wdata; ref_vld[cpu_addr[7:2]] = 1; end
            else exp_cpu_rd = ref_read(cpu_addr);
            cpu_req = 0; last_ldr = 0;
          end else if (front == 1) begin
            if (ldr_we) begin ref_mem[ldr_addr[7:2]] = ldr_wdata; ref_vld[ldr_addr[7:2]] = 1; end
            else exp_ldr_rd = ref_read(ldr_addr);
            ldr_req = 0; last_ldr = 1;
          end
          total_cnt++;
          if (cpu_rdata !== exp_cpu_rd || ldr_rdata !== exp_ldr_rd)
            $display("FAIL rand_rdata r%0d: got %h %h want %h %h", r, cpu_rdata, ldr_rdata,
                     exp_cpu_rd, exp_ldr_rd);
          else pass_cnt++;
        end
      end
      total_cnt++;
      if (who_q.size() !== 0) $display("FAIL rand_timeout r%0d: got %0d pending want 0", r,
                                       who_q.size());
      else pass_cnt++;
      cpu_req = 0; ldr_req = 0;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_cpu_read();
    test_ldr_write();
    test_round_robin();
    test_back_to_back();
    test_reset_mid();
    test_drop_mid();
    test_lat1();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory between two requesters:
  - the CPU datapath port, which issues instruction fetches and load/store accesses;
  - a loader/debug port, which preloads programs and inspects memory.
- Serialises accesses, sequences the fixed-latency memory strobes, and returns read data with a one-cycle acknowledge.
- Sits between the datapath's memory interface and the memory array; the controller stalls its state machine until cpu_ack.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 2, number of cycles mem_read/mem_write are held per access; legal values are 1 and above.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low reset.
- cpu_req  in  1  CPU access request; held high until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  CPU read data; valid with cpu_ack.
- cpu_ack  out  1  one-cycle completion pulse to the CPU.
- ldr_req  in  1  loader request; same rules as cpu_req.
- ldr_we  in  1  loader write enable.
- ldr_addr  in  ADDR_W  loader address.
- ldr_wdata  in  DATA_W  loader write data.
- ldr_rdata  out  DATA_W  loader read data.
- ldr_ack  out  1  one-cycle completion pulse to the loader.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  ADDR_W  registered memory address.
- mem_wdata  out  DATA_W  registered memory write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high in ACCESS and DONE.
- grant_ldr  out  1  1 = the current or last grant went to the loader.

Behaviour:
- Reset (reset==0 sampled at a clock edge):
  - state=IDLE; all outputs 0; last_grant=LDR, so the CPU wins the first tie.
  - Reset mid-operation aborts the access: strobes drop the cycle after reset is sampled and no ack is issued.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If no request is high, stay in IDLE.
  - Otherwise pick a winner. A single requester wins. If both request, round-robin: grant the requester that was not last_grant.
  - On the edge, latch the winner's addr/we/wdata into mem_addr/mem_wdata and an internal we register.
  - Set grant_ldr and last_grant, load cnt=MEM_LAT-1, then go to ACCESS.
- ACCESS:
  - mem_read=~we and mem_write=we, held for exactly MEM_LAT cycles; mem_addr and mem_wdata are stable throughout.
  - cnt decrements each cycle. When cnt==0, on that edge, capture mem_rdata into the winner's rdata register (reads only) and go to DONE.
- DONE:
  - Strobes are 0. The winner's ack is 1 for exactly this cycle; the other ack stays 0. Then go to IDLE.
- Latency: request seen in IDLE at cycle T gives strobes in T+1..T+MEM_LAT and ack at T+MEM_LAT+1.
  - Minimum access period is MEM_LAT+2 cycles.
- Data hold rules:
  - Writes do not modify either rdata register.
  - Each rdata register holds its value until that requester's next completed read.
- Requester rules:
  - A requester must drop req in the IDLE cycle after its ack. A req still high in that cycle is treated as a new request.
  - Dropping req during ACCESS does not abort the access; it completes and ack still pulses.
- The loser's request is not lost. It stays pending and wins at the next IDLE, because last_grant now points at the winner.
- Input changes on either port during ACCESS or DONE are ignored.
- MEM_LAT=1: ACCESS lasts one cycle.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: fixed priority. The CPU always wins when both request; last_grant is still tracked for grant_ldr but not used for arbitration. The loader can starve while the CPU requests back-to-back.
- Undefined: round-robin as described in Behaviour.

Test Plan:
- CPU read alone, MEM_LAT=2:
  - Stimulus: cpu_req=1, cpu_we=0, cpu_addr=0x10, memory returns 0xDEADBEEF.
  - Required: mem_read high for 2 cycles with mem_addr=0x10; cpu_ack one cycle later with cpu_rdata=0xDEADBEEF; ldr_ack stays 0.
- Loader write alone:
  - Stimulus: ldr_addr=0x40, ldr_wdata=0x12345678, ldr_we=1.
  - Required: mem_write held 2 cycles with mem_wdata=0x12345678; ldr_ack pulses; cpu_rdata and ldr_rdata unchanged.
- Simultaneous requests, repeated 3 times, each requester releasing req after its ack and re-asserting:
  - Default build: grant order CPU, LDR, CPU, LDR, CPU, LDR.
  - With ARB_FIXED_PRIO_EN and both reqs held continuously: CPU served every time, ldr_ack never asserted.
- Reset mid-ACCESS:
  - Stimulus: drive reset=0 in the second ACCESS cycle.
  - Required: next cycle mem_read=0, state IDLE, no ack, grant_ldr=0. After release, a pending cpu_req is served normally.
- Requester drops req mid-ACCESS:
  - Stimulus: cpu_req falls during ACCESS.
  - Required: access completes and cpu_ack pulses once; no further access is started.
- MEM_LAT=1 back-to-back CPU reads at 0x0 and 0x4:
  - Required: each read takes 3 cycles; the two acks are 3 cycles apart with the correct rdata for each.
